// File: rtl/imsic_msi_decoder_pkg.sv
// Shared types and constants for the IMSIC MSI decoder.
package imsic_msi_decoder_pkg;

  // Page offsets of the two setipnum registers inside each interrupt-file page.
  localparam logic [11:0] SetEipnumLeOff = 12'h000;
  localparam logic [11:0] SetEipnumBeOff = 12'h004;

  // Entry field widths are fixed upper bounds; the decoder truncates into them.
  localparam int unsigned EntryHartW = 8;
  localparam int unsigned EntryFileW = 6;
  localparam int unsigned EntryIdW   = 11;

  typedef struct packed {
    logic [EntryHartW-1:0] hart;
    logic [EntryFileW-1:0] file;
    logic [EntryIdW-1:0]   id;
  } imsic_msi_entry_t;

  // Bits of S-range page index that select the file within a hart group.
  function automatic int unsigned sgroup_w(input int unsigned nr_files);
    if (nr_files <= 2) return 1;
    return $clog2(nr_files - 1);
  endfunction

endpackage

// File: rtl/imsic_msi_decoder_if.sv
// Simple valid/ready MSI write port from the bus protocol converter.
interface imsic_msi_decoder_if #(
  parameter int unsigned AddrW = 32,
  parameter int unsigned DataW = 32
);
  logic               wr_valid;
  logic               wr_ready;
  logic [AddrW-1:0]   wr_addr;
  logic [DataW-1:0]   wr_data;
  logic [DataW/8-1:0] wr_be;
  logic               wr_err;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_be,
    input  wr_ready, wr_err
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_be,
    output wr_ready, wr_err
  );
endinterface

// File: rtl/imsic_msi_decoder_fifo.sv
// Generic entry FIFO; Depth must be a power of two so pointers wrap naturally.
module imsic_msi_decoder_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer and occupancy state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + CntW'(1);
      else if (!push_ok && pop_ok) cnt_q <= cnt_q - CntW'(1);
    end
  end

  // Storage; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/imsic_msi_decoder.sv
// Decodes MSI writes into per-hart, per-file setipnum strobes via a small FIFO.
module imsic_msi_decoder
  import imsic_msi_decoder_pkg::*;
#(
  parameter int unsigned NrHarts     = 4,
  parameter int unsigned NrInptFiles = 3,
  parameter int unsigned NrSources   = 64,
  parameter int unsigned AddrW       = 32,
  parameter int unsigned DataW       = 32,
  parameter int unsigned FifoDepth   = 4,
  parameter logic [AddrW-1:0] MBaseAddr = AddrW'(32'h2400_0000),
  parameter logic [AddrW-1:0] SBaseAddr = AddrW'(32'h2800_0000),
  localparam int unsigned NrSourcesW = $clog2(NrSources)
) (
  input  logic                                              i_clk,
  input  logic                                              ni_rst,
  imsic_msi_decoder_if.slave                                wr,
  input  logic [NrHarts-1:0]                                i_hart_ready,
  output logic [NrHarts-1:0][NrInptFiles-1:0][NrSourcesW-1:0] o_setipnum,
  output logic [NrHarts-1:0][NrInptFiles-1:0]               o_setipnum_we,
  output logic [15:0]                                       o_drop_cnt,
  input  logic                                              i_drop_cnt_clr
);
  localparam int unsigned SGroupW = sgroup_w(NrInptFiles);
  localparam int unsigned PageW   = AddrW - 12;
  localparam logic [PageW-1:0] FileMask = PageW'((1 << SGroupW) - 1);

  logic [31:0]      word, id;
  logic [3:0]       be4;
  logic [PageW-1:0] m_page, s_page, hart_full, file_full;
  logic             in_m, in_s, off_le, off_be, addr_ok, id_ok;
  logic             accept, push, pop, drop, hart_sel;
  logic             full, empty;
  imsic_msi_entry_t push_entry, head;

  logic [NrHarts-1:0][NrInptFiles-1:0][NrSourcesW-1:0] setipnum_d, setipnum_q;
  logic [NrHarts-1:0][NrInptFiles-1:0]                 we_d, we_q;
  logic                                                err_q;
  logic [15:0]                                         drop_cnt_q;

  // 64-bit bus: addr[2] picks the 32-bit lane holding the register.
  if (DataW == 64) begin : g_lane64
    assign word = wr.wr_addr[2] ? wr.wr_data[DataW-1 -: 32] : wr.wr_data[31:0];
    assign be4  = wr.wr_addr[2] ? wr.wr_be[DataW/8-1 -: 4] : wr.wr_be[3:0];
  end else begin : g_lane32
    assign word = wr.wr_data;
    assign be4  = wr.wr_be;
  end

  // Address decode and validation of the incoming write.
  always_comb begin
    m_page    = PageW'((wr.wr_addr - MBaseAddr) >> 12);
    s_page    = PageW'((wr.wr_addr - SBaseAddr) >> 12);
    in_m      = (wr.wr_addr >= MBaseAddr) && (m_page < PageW'(NrHarts));
    in_s      = (wr.wr_addr >= SBaseAddr) && (s_page < PageW'(NrHarts << SGroupW));
    hart_full = '0;
    file_full = '0;
    if (in_m) begin
      hart_full = m_page;
    end else if (in_s) begin
      hart_full = s_page >> SGroupW;
      file_full = (s_page & FileMask) + PageW'(1);
    end
    off_le  = (wr.wr_addr[11:0] == SetEipnumLeOff);
    off_be  = (wr.wr_addr[11:0] == SetEipnumBeOff);
    addr_ok = (in_m || in_s) && (hart_full < PageW'(NrHarts)) &&
              (file_full < PageW'(NrInptFiles)) && (off_le || off_be) && (be4 == 4'hF);
    id      = off_be ? {word[7:0], word[15:8], word[23:16], word[31:24]} : word;
    id_ok   = (id != '0) && (id < 32'(NrSources));
  end

  assign wr.wr_ready = !full;
  assign accept      = wr.wr_valid && wr.wr_ready;
  assign push        = accept && addr_ok && id_ok;
  assign drop        = accept && !(addr_ok && id_ok);

  // Pack the decoded write into a FIFO entry.
  always_comb begin
    push_entry      = '0;
    push_entry.hart = EntryHartW'(hart_full);
    push_entry.file = EntryFileW'(file_full);
    push_entry.id   = EntryIdW'(id);
  end

  imsic_msi_decoder_fifo #(
    .Width ($bits(imsic_msi_entry_t)),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (ni_rst),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Pop when the head's hart is ready; head-of-line blocks everything behind it.
  always_comb begin
    hart_sel   = 1'b0;
    setipnum_d = '0;
    we_d       = '0;
    for (int unsigned h = 0; h < NrHarts; h++) begin
      if (head.hart == EntryHartW'(h)) hart_sel = i_hart_ready[h];
    end
    pop = !empty && hart_sel;
    for (int unsigned h = 0; h < NrHarts; h++) begin
      for (int unsigned f = 0; f < NrInptFiles; f++) begin
        if (pop && head.hart == EntryHartW'(h) && head.file == EntryFileW'(f)) begin
          we_d[h][f]       = 1'b1;
          setipnum_d[h][f] = NrSourcesW'(head.id);
        end
      end
    end
  end

  // Output register, error pulse and saturating drop counter.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      setipnum_q <= '0;
      we_q       <= '0;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      setipnum_q <= setipnum_d;
      we_q       <= we_d;
      err_q      <= accept && !addr_ok;
      if (i_drop_cnt_clr)                     drop_cnt_q <= '0;
      else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign o_setipnum    = setipnum_q;
  assign o_setipnum_we = we_q;
  assign o_drop_cnt    = drop_cnt_q;
  assign wr.wr_err     = err_q;

endmodule

// File: tb/tb_imsic_msi_decoder.sv
// Directed bench for imsic_msi_decoder with default parameters.
module tb_imsic_msi_decoder;
  logic                  clk, rst_n, drop_clr;
  logic [3:0]            hart_ready;
  logic [3:0][2:0][5:0]  setipnum;
  logic [3:0][2:0]       setipnum_we;
  logic [15:0]           drop_cnt;
  int                    n_checks, n_errors, cyc, slot_bad, multi_bad;

  typedef struct {int hart; int file; int id; int cyc;} ev_t;
  ev_t log_q[$];

  imsic_msi_decoder_if #(.AddrW(32), .DataW(32)) bus ();

  imsic_msi_decoder #(
    .NrHarts(4), .NrInptFiles(3), .NrSources(64), .AddrW(32), .DataW(32), .FifoDepth(4)
  ) dut (
    .i_clk          (clk),
    .ni_rst         (rst_n),
    .wr             (bus.slave),
    .i_hart_ready   (hart_ready),
    .o_setipnum     (setipnum),
    .o_setipnum_we  (setipnum_we),
    .o_drop_cnt     (drop_cnt),
    .i_drop_cnt_clr (drop_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Strobe log plus checks that idle slots stay zero and strobes are one-hot.
  always @(negedge clk) begin
    int nwe;
    nwe = 0;
    for (int h = 0; h < 4; h++) begin
      for (int f = 0; f < 3; f++) begin
        if (setipnum_we[h][f] === 1'b1) begin
          nwe++;
          log_q.push_back('{h, f, int'(setipnum[h][f]), cyc});
        end else if (setipnum[h][f] !== 6'd0) begin
          slot_bad++;
        end
      end
    end
    if (nwe > 1) multi_bad++;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drives one write; returns at #1 after the accepting edge.
  task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                             output bit ok);
    int n;
    n = 0;
    bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_be = be;
    while (bus.wr_ready !== 1'b1 && n < 20) begin step(1); n++; end
    ok = (bus.wr_ready === 1'b1);
    step(1);
    bus.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; drop_clr = 1'b0; hart_ready = 4'hF;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
    #12;
    n_checks++; if (bus.wr_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready: got %0b want 1", bus.wr_ready); end
    n_checks++; if (bus.wr_err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %0b want 0", bus.wr_err); end
    n_checks++; if (setipnum_we !== '0) begin n_errors++; $display("FAIL rst_we: got %0h want 0", setipnum_we); end
    n_checks++; if (setipnum !== '0) begin n_errors++; $display("FAIL rst_ip: got %0h want 0", setipnum); end
    n_checks++; if (drop_cnt !== 16'd0) begin n_errors++; $display("FAIL rst_cnt: got %0h want 0", drop_cnt); end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_m_write();
    bit ok;
    logic [3:0][2:0] exp_we;
    logic [3:0][2:0][5:0] exp_ip;
    log_q.delete();
    drive_write(32'h2400_1000, 32'd5, 4'hF, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL m_accept: got %0b want 1", ok); end
    n_checks++; if (bus.wr_err !== 1'b0) begin n_errors++; $display("FAIL m_err: got %0b want 0", bus.wr_err); end
    n_checks++; if (setipnum_we !== '0) begin n_errors++; $display("FAIL m_early: got %0h want 0", setipnum_we); end
    step(1);
    exp_we = '0; exp_we[1][0] = 1'b1;
    exp_ip = '0; exp_ip[1][0] = 6'd5;
    n_checks++; if (setipnum_we !== exp_we) begin n_errors++; $display("FAIL m_we: got %0h want %0h", setipnum_we, exp_we); end
    n_checks++; if (setipnum !== exp_ip) begin n_errors++; $display("FAIL m_ip: got %0h want %0h", setipnum, exp_ip); end
    step(1);
    n_checks++; if (setipnum_we !== '0) begin n_errors++; $display("FAIL m_one_cycle: got %0h want 0", setipnum_we); end
    n_checks++; if (log_q.size() !== 1) begin n_errors++; $display("FAIL m_count: got %0d want 1", log_q.size()); end
  endtask

  task automatic test_be_swap();
    bit ok;
    logic [3:0][2:0] exp_we;
    logic [3:0][2:0][5:0] exp_ip;
    drive_write(32'h2800_5004, 32'h0700_0000, 4'hF, ok);
    n_checks++; if (bus.wr_err !== 1'b0) begin n_errors++; $display("FAIL be_err: got %0b want 0", bus.wr_err); end
    step(1);
    exp_we = '0; exp_we[2][2] = 1'b1;
    exp_ip = '0; exp_ip[2][2] = 6'd7;
    n_checks++; if (setipnum_we !== exp_we) begin n_errors++; $display("FAIL be_we: got %0h want %0h", setipnum_we, exp_we); end
    n_checks++; if (setipnum !== exp_ip) begin n_errors++; $display("FAIL be_ip: got %0h want %0h", setipnum, exp_ip); end
    step(1);
  endtask

  task automatic test_drops();
    bit ok;
    log_q.delete();
    drive_write(32'h2400_4000, 32'd5, 4'hF, ok);
    n_checks++; if (bus.wr_err !== 1'b1) begin n_errors++; $display("FAIL hart4_err: got %0b want 1", bus.wr_err); end
    n_checks++; if (drop_cnt !== 16'd1) begin n_errors++; $display("FAIL hart4_cnt: got %0d want 1", drop_cnt); end
    step(1);
    n_checks++; if (bus.wr_err !== 1'b0) begin n_errors++; $display("FAIL err_pulse: got %0b want 0", bus.wr_err); end
    drive_write(32'h2400_0000, 32'd0, 4'hF, ok);
    n_checks++; if (bus.wr_err !== 1'b0) begin n_errors++; $display("FAIL id0_err: got %0b want 0", bus.wr_err); end
    drive_write(32'h2400_0000, 32'd64, 4'hF, ok);
    n_checks++; if (bus.wr_err !== 1'b0) begin n_errors++; $display("FAIL id64_err: got %0b want 0", bus.wr_err); end
    n_checks++; if (drop_cnt !== 16'd3) begin n_errors++; $display("FAIL id_cnt: got %0d want 3", drop_cnt); end
    drive_write(32'h2400_0000, 32'd5, 4'h7, ok);
    n_checks++; if (bus.wr_err !== 1'b1) begin n_errors++; $display("FAIL be7_err: got %0b want 1", bus.wr_err); end
    n_checks++; if (drop_cnt !== 16'd4) begin n_errors++; $display("FAIL be7_cnt: got %0d want 4", drop_cnt); end
    drive_write(32'h2400_0008, 32'd5, 4'hF, ok);
    n_checks++; if (bus.wr_err !== 1'b1) begin n_errors++; $display("FAIL off8_err: got %0b want 1", bus.wr_err); end
    drive_write(32'h3000_0000, 32'd5, 4'hF, ok);
    n_checks++; if (bus.wr_err !== 1'b1) begin n_errors++; $display("FAIL range_err: got %0b want 1", bus.wr_err); end
    n_checks++; if (drop_cnt !== 16'd6) begin n_errors++; $display("FAIL range_cnt: got %0d want 6", drop_cnt); end
    step(3);
    n_checks++; if (log_q.size() !== 0) begin n_errors++; $display("FAIL drop_strobes: got %0d want 0", log_q.size()); end
  endtask

  task automatic test_backpressure();
    log_q.delete();
    hart_ready = 4'h0;
    bus.wr_valid = 1'b1; bus.wr_addr = 32'h2400_0000; bus.wr_be = 4'hF;
    for (int i = 1; i <= 4; i++) begin
      bus.wr_data = i;
      n_checks++; if (bus.wr_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready%0d: got %0b want 1", i, bus.wr_ready); end
      step(1);
    end
    bus.wr_data = 32'd5;
    n_checks++; if (bus.wr_ready !== 1'b0) begin n_errors++; $display("FAIL bp_full: got %0b want 0", bus.wr_ready); end
    step(2);
    n_checks++; if (bus.wr_ready !== 1'b0) begin n_errors++; $display("FAIL bp_hold: got %0b want 0", bus.wr_ready); end
    n_checks++; if (log_q.size() !== 0) begin n_errors++; $display("FAIL bp_blocked: got %0d want 0", log_q.size()); end
    hart_ready = 4'hF;
    step(1);
    n_checks++; if (bus.wr_ready !== 1'b1) begin n_errors++; $display("FAIL bp_freed: got %0b want 1", bus.wr_ready); end
    step(1);
    bus.wr_valid = 1'b0;
    step(6);
    n_checks++; if (log_q.size() !== 5) begin n_errors++; $display("FAIL bp_count: got %0d want 5", log_q.size()); end
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      n_checks++;
      if (log_q[i].hart !== 0 || log_q[i].file !== 0 || log_q[i].id !== i + 1 ||
          log_q[i].cyc !== log_q[0].cyc + i) begin
        n_errors++;
        $display("FAIL bp_order%0d: got h%0d f%0d id%0d c%0d want h0 f0 id%0d c%0d", i,
                 log_q[i].hart, log_q[i].file, log_q[i].id, log_q[i].cyc, i + 1, log_q[0].cyc + i);
      end
    end
  endtask

  task automatic test_hol();
    bit ok;
    int id0, id1, h0, h1;
    log_q.delete();
    hart_ready = 4'h0;
    drive_write(32'h2400_0000, 32'd9, 4'hF, ok);
    drive_write(32'h2400_1000, 32'd10, 4'hF, ok);
    hart_ready = 4'b0010;
    step(4);
    n_checks++; if (log_q.size() !== 0) begin n_errors++; $display("FAIL hol_blocked: got %0d want 0", log_q.size()); end
    hart_ready = 4'b0011;
    step(4);
    n_checks++; if (log_q.size() !== 2) begin n_errors++; $display("FAIL hol_count: got %0d want 2", log_q.size()); end
    h0  = (log_q.size() > 0) ? log_q[0].hart : -1;
    id0 = (log_q.size() > 0) ? log_q[0].id : -1;
    h1  = (log_q.size() > 1) ? log_q[1].hart : -1;
    id1 = (log_q.size() > 1) ? log_q[1].id : -1;
    n_checks++; if (h0 !== 0 || id0 !== 9) begin n_errors++; $display("FAIL hol_first: got h%0d id%0d want h0 id9", h0, id0); end
    n_checks++; if (h1 !== 1 || id1 !== 10) begin n_errors++; $display("FAIL hol_second: got h%0d id%0d want h1 id10", h1, id1); end
    hart_ready = 4'hF;
  endtask

  task automatic test_counter();
    drop_clr = 1'b1;
    step(1);
    drop_clr = 1'b0;
    n_checks++; if (drop_cnt !== 16'd0) begin n_errors++; $display("FAIL cnt_clr: got %0h want 0", drop_cnt); end
    bus.wr_valid = 1'b1; bus.wr_addr = 32'h2400_0000; bus.wr_data = 32'd0; bus.wr_be = 4'hF;
    step(65534);
    n_checks++; if (drop_cnt !== 16'hFFFE) begin n_errors++; $display("FAIL cnt_fffe: got %0h want fffe", drop_cnt); end
    step(1);
    n_checks++; if (drop_cnt !== 16'hFFFF) begin n_errors++; $display("FAIL cnt_ffff: got %0h want ffff", drop_cnt); end
    step(3);
    n_checks++; if (drop_cnt !== 16'hFFFF) begin n_errors++; $display("FAIL cnt_sat: got %0h want ffff", drop_cnt); end
    drop_clr = 1'b1;
    step(1);
    drop_clr = 1'b0; bus.wr_valid = 1'b0;
    n_checks++; if (drop_cnt !== 16'd0) begin n_errors++; $display("FAIL cnt_clr_prio: got %0h want 0", drop_cnt); end
    bus.wr_valid = 1'b1;
    step(1);
    bus.wr_valid = 1'b0;
    n_checks++; if (drop_cnt !== 16'd1) begin n_errors++; $display("FAIL cnt_after_clr: got %0h want 1", drop_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    hart_ready = 4'h0;
    for (int i = 3; i <= 5; i++) drive_write(32'h2400_2000, i, 4'hF, ok);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (setipnum_we !== '0) begin n_errors++; $display("FAIL mid_we: got %0h want 0", setipnum_we); end
    n_checks++; if (setipnum !== '0) begin n_errors++; $display("FAIL mid_ip: got %0h want 0", setipnum); end
    n_checks++; if (bus.wr_ready !== 1'b1) begin n_errors++; $display("FAIL mid_ready: got %0b want 1", bus.wr_ready); end
    n_checks++; if (drop_cnt !== 16'd0) begin n_errors++; $display("FAIL mid_cnt: got %0h want 0", drop_cnt); end
    #2;
    rst_n = 1'b1;
    log_q.delete();
    hart_ready = 4'hF;
    step(5);
    n_checks++; if (log_q.size() !== 0) begin n_errors++; $display("FAIL mid_strobes: got %0d want 0", log_q.size()); end
    n_checks++; if (bus.wr_ready !== 1'b1) begin n_errors++; $display("FAIL mid_ready2: got %0b want 1", bus.wr_ready); end
  endtask

  task automatic test_hygiene();
    n_checks++; if (slot_bad !== 0) begin n_errors++; $display("FAIL idle_slots: got %0d want 0", slot_bad); end
    n_checks++; if (multi_bad !== 0) begin n_errors++; $display("FAIL one_hot: got %0d want 0", multi_bad); end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; slot_bad = 0; multi_bad = 0;
    test_reset();
    test_m_write();
    test_be_swap();
    test_drops();
    test_backpressure();
    test_hol();
    test_counter();
    test_reset_mid();
    test_hygiene();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
